taiga_fifo_safe: RTL and testbench
==================================

# taiga_fifo_safe

Parametrised, overflow/underflow-safe synchronous FIFO for arbitrary (non-power-of-two) depths, used wherever a unit queue needs occupancy visibility: fetch buffers, load/store queues, writeback staging. It extends the existing small-FIFO behaviour with several additions:
- exact-depth circular storage;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- synchronous flush;
- sticky error flags.

Push and pop that would corrupt state are dropped rather than trusted to the caller. Reads are first-word-fall-through.

## Interface
- DATA_WIDTH, 32, payload width (≥1)
- FIFO_DEPTH, 6, number of entries, any integer ≥2; no rounding to a power of two
- AF_THRESH, FIFO_DEPTH-1, almost_full asserted when count ≥ AF_THRESH (1..FIFO_DEPTH)
- AE_THRESH, 1, almost_empty asserted when count ≤ AE_THRESH (0..FIFO_DEPTH-1)
- CW (localparam), $clog2(FIFO_DEPTH+1), count width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  enqueue data_in this cycle
- data_in  in  DATA_WIDTH  payload
- pop  in  1  dequeue head this cycle
- flush  in  1  synchronous discard of all entries
- err_clr  in  1  clear sticky error flags
- data_out  out  DATA_WIDTH  head entry, FWFT
- valid  out  1  count ≠ 0
- full  out  1  count == FIFO_DEPTH
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  CW  current occupancy
- overflow  out  1  sticky: a push was dropped
- underflow  out  1  sticky: a pop was dropped

## Operation
- State:
  - storage array [FIFO_DEPTH];
  - wr_idx and rd_idx, width $clog2(FIFO_DEPTH);
  - count.
- Only the indices, count and error flags are reset; storage is not.
- Index advance is modulo FIFO_DEPTH: the value FIFO_DEPTH-1 wraps to 0. There is no bit-slice wrap.
- Effective handshakes:
  - pop_ok = pop & valid & ~flush
  - push_ok = push & ~flush & (~full | pop_ok)
- On push_ok: storage[wr_idx] ← data_in, then advance wr_idx.
- On pop_ok: advance rd_idx.
- count next = count + push_ok − pop_ok. This is never below 0 and never above FIFO_DEPTH.
- Errors:
  - A push that is not push_ok while flush=0 sets overflow.
  - A pop that is not pop_ok while flush=0 sets underflow.
  - err_clr clears both flags. If an error and err_clr occur in the same cycle, set wins.
- Flush: wr_idx, rd_idx and count all go to 0 and push/pop are ignored. No error flags are set, and existing flags are untouched.
- Boundary cases:
  - Full with push+pop: both accepted and count unchanged, since the popped slot is reused.
  - Empty with push+pop: push accepted, pop dropped, underflow set, count becomes 1.
  - Push when full without pop: dropped, storage untouched, overflow set.
- data_out = storage[rd_idx]. It is combinational from registered state and is don't-care while valid=0.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - count=0, valid=0, full=0, almost_full=0, overflow=0, underflow=0;
  - almost_empty=1;
  - data_out undefined.
- Latency: a word pushed in cycle N appears on data_out with valid=1 in cycle N+1 if the FIFO was empty.
- All status outputs are functions of registered count only. There are no paths from push/pop/flush to any output.
- A flush asserted in cycle N gives count=0 and valid=0 in cycle N+1.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Structure
- No new shared-package typedefs are needed. Parameters stay local; CW is a localparam.
- Sub-module: taiga_fifo_mod_counter (parameter MOD). It is a modulo-MOD incrementing index with an enable and a synchronous clear, instantiated twice, once for wr_idx and once for rd_idx.
- Status flags are compare logic on count in the top module.
- Elaboration assertions check the ranges of FIFO_DEPTH, AF_THRESH and AE_THRESH.

## Test plan
All scenarios use DATA_WIDTH=32, FIFO_DEPTH=6, AF_THRESH=5, AE_THRESH=1.
- Fill and drain:
  - Push 0x10..0x15 over 6 cycles, then pop 6 → outputs 0x10..0x15 in order.
  - almost_empty deasserts at count=2, almost_full asserts at count=5, full at count=6.
- Wrap-around: 20 cycles of interleaved push/pop with count held at 3 → data order preserved across index wrap 5→0, no error flags.
- Overflow:
  - At count=6, push 0xDEAD without pop → count stays 6, head unchanged, overflow=1.
  - Then err_clr → overflow=0.
- Simultaneous ops at both ends:
  - At full, push+pop → count 6, pushed word emerges after the 5 older words.
  - At empty, push+pop → count 1, underflow=1.
- Flush: at count=4, assert flush together with push and pop → next cycle count=0, valid=0, no flags set; a following push is read back correctly.
- Async reset: drop rst_n mid-cycle at count=3 → outputs reach reset values before the next clk edge; operation resumes cleanly after release.

Source files
------------

// File: rtl/taiga_fifo_safe_pkg.sv
// Shared defaults and sizing helper for the overflow/underflow-safe FIFO.
package taiga_fifo_safe_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 6;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/taiga_fifo_safe_if.sv
// Producer/consumer bus of the safe FIFO: handshake, payload and status.
interface taiga_fifo_safe_if
  import taiga_fifo_safe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CW         = count_width(DEF_FIFO_DEPTH)
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop, flush, err_clr,
    input  data_out, valid, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, flush, err_clr,
    output data_out, valid, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/taiga_fifo_mod_counter.sv
// Modulo-MOD incrementing index with enable and synchronous clear.
module taiga_fifo_mod_counter #(
  parameter  int unsigned MOD = 6,
  localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] idx
);

  // Explicit compare-and-wrap so non-power-of-two MOD never reaches an unused code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= (idx == W'(MOD - 1)) ? '0 : idx + W'(1);
    end
  end

endmodule

// File: rtl/taiga_fifo_safe.sv
// Exact-depth FWFT FIFO with occupancy, programmable almost flags, flush and sticky errors.
module taiga_fifo_safe
  import taiga_fifo_safe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = 1
) (
  input logic             clk,
  input logic             rst_n,
  taiga_fifo_safe_if.slave bus
);

  localparam int unsigned CW = count_width(FIFO_DEPTH);
  localparam int unsigned IW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("taiga_fifo_safe: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("taiga_fifo_safe: AF_THRESH must be in 1..FIFO_DEPTH");
  end
  if (AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("taiga_fifo_safe: AE_THRESH must be in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  valid_q;
  logic                  full_q;
  logic                  almost_full_q;
  logic                  almost_empty_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_set;
  logic                  unf_set;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
  assign pop_ok  = bus.pop & valid_q & ~bus.flush;
  assign push_ok = bus.push & ~bus.flush & (~full_q | pop_ok);
  assign ovf_set = bus.push & ~bus.flush & ~push_ok;
  assign unf_set = bus.pop & ~bus.flush & ~pop_ok;

  taiga_fifo_mod_counter #(.MOD(FIFO_DEPTH)) u_wr_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (push_ok),
    .clr   (bus.flush),
    .idx   (wr_idx)
  );

  taiga_fifo_mod_counter #(.MOD(FIFO_DEPTH)) u_rd_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pop_ok),
    .clr   (bus.flush),
    .idx   (rd_idx)
  );

  // Payload storage carries no reset; valid gates its use.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= bus.data_in;
    end
  end

  always_comb begin
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else if (push_ok && !pop_ok) begin
      count_nxt = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // Status is compared against the next count so every flag is a flop tracking count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      valid_q        <= 1'b0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      count_q        <= count_nxt;
      valid_q        <= (count_nxt != '0);
      full_q         <= (count_nxt == CW'(FIFO_DEPTH));
      almost_full_q  <= (count_nxt >= CW'(AF_THRESH));
      almost_empty_q <= (count_nxt <= CW'(AE_THRESH));
      overflow_q     <= ovf_set | (overflow_q & ~bus.err_clr);
      underflow_q    <= unf_set | (underflow_q & ~bus.err_clr);
    end
  end

  assign bus.data_out     = mem[rd_idx];
  assign bus.valid        = valid_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_taiga_fifo_safe.sv
// Directed bench for taiga_fifo_safe: queue-based reference model plus literal spot checks.
module tb_taiga_fifo_safe;

  localparam int unsigned DEPTH = 6;
  localparam int unsigned AF    = 5;
  localparam int unsigned AE    = 1;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   run;

  taiga_fifo_safe_if #(.DATA_WIDTH(32), .CW(3)) bus ();

  taiga_fifo_safe #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words and two sticky bits.
  logic [31:0] q[$];
  bit          m_ovf;
  bit          m_unf;
  bit          m_pop;
  bit          m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_pop  = 1'b0;
      m_push = 1'b0;
      if (bus.flush) begin
        q.delete();
      end else begin
        m_pop  = bus.pop && (q.size() > 0);
        m_push = bus.push && ((q.size() < DEPTH) || m_pop);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(bus.data_in);
      end
      m_ovf = (!bus.flush && bus.push && !m_push) || (m_ovf && !bus.err_clr);
      m_unf = (!bus.flush && bus.pop && !m_pop) || (m_unf && !bus.err_clr);
    end
  end

  // Every cycle out of reset, all outputs must agree with the model.
  always @(negedge clk) begin
    if (run && rst_n === 1'b1) begin
      chk("m_count", 32'(bus.count), 32'(q.size()));
      chk("m_valid", 32'(bus.valid), 32'(q.size() != 0));
      chk("m_full", 32'(bus.full), 32'(q.size() == DEPTH));
      chk("m_almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
      chk("m_almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AE));
      chk("m_overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("m_underflow", 32'(bus.underflow), 32'(m_unf));
      if (q.size() != 0) chk("m_data_out", bus.data_out, q[0]);
    end
  end

  task automatic cyc(input bit p, input logic [31:0] d, input bit o, input bit f, input bit e);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = o;
    bus.flush   = f;
    bus.err_clr = e;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.data_in = '0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ae_tbl;
    logic [5:0]  af_tbl;
    logic [5:0]  full_tbl;
    logic [31:0] drain_exp [6];

    tests = 0;
    fails = 0;
    run   = 1'b0;
    rst_n = 1'b0;
    bus.push    = 1'b0;
    bus.data_in = '0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_almost_full", 32'(bus.almost_full), 32'd0);
    chk("rst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_underflow", 32'(bus.underflow), 32'd0);

    // Fill 0x10..0x15; bit i of each table is the flag at count i+1.
    ae_tbl   = 6'b000001;
    af_tbl   = 6'b110000;
    full_tbl = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_almost_empty", 32'(bus.almost_empty), 32'(ae_tbl[i]));
      chk("fill_almost_full", 32'(bus.almost_full), 32'(af_tbl[i]));
      chk("fill_full", 32'(bus.full), 32'(full_tbl[i]));
      chk("fill_head", bus.data_out, 32'h10);
    end

    // Push into a full FIFO is dropped and flagged.
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd6);
    chk("ovf_head", bus.data_out, 32'h10);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Full push+pop reuses the freed slot.
    cyc(1'b1, 32'hA0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 32'(bus.count), 32'd6);
    chk("fullpp_overflow", 32'(bus.overflow), 32'd0);
    drain_exp = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'hA0};
    for (int i = 0; i < 6; i++) begin
      chk("drain_head", bus.data_out, drain_exp[i]);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_valid", 32'(bus.valid), 32'd0);

    // Empty push+pop: push lands, pop is dropped.
    cyc(1'b1, 32'hB0, 1'b1, 1'b0, 1'b0);
    chk("emptypp_count", 32'(bus.count), 32'd1);
    chk("emptypp_underflow", 32'(bus.underflow), 32'd1);
    chk("emptypp_head", bus.data_out, 32'hB0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("unf_clr", 32'(bus.underflow), 32'd0);
    chk("unf_clr_count", 32'(bus.count), 32'd0);

    // Steady occupancy of 3 across many index wraps.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_head", bus.data_out, 32'h30 + 32'(i));
      cyc(1'b1, 32'h33 + 32'(i), 1'b1, 1'b0, 1'b0);
      chk("wrap_count", 32'(bus.count), 32'd3);
    end
    chk("wrap_head_end", bus.data_out, 32'h44);
    chk("wrap_overflow", 32'(bus.overflow), 32'd0);
    chk("wrap_underflow", 32'(bus.underflow), 32'd0);
    cyc(1'b1, 32'h47, 1'b0, 1'b0, 1'b0);
    chk("preflush_count", 32'(bus.count), 32'd4);

    // Flush wins over simultaneous push and pop, and sets no flags.
    cyc(1'b1, 32'hEE, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.valid), 32'd0);
    chk("flush_overflow", 32'(bus.overflow), 32'd0);
    chk("flush_underflow", 32'(bus.underflow), 32'd0);
    cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    chk("postflush_head", bus.data_out, 32'h77);
    chk("postflush_count", 32'(bus.count), 32'd1);

    // Asynchronous reset in the middle of a cycle at count 3.
    cyc(1'b1, 32'h78, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h79, 1'b0, 1'b0, 1'b0);
    chk("prerst_count", 32'(bus.count), 32'd3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_valid", 32'(bus.valid), 32'd0);
    chk("arst_almost_empty", 32'(bus.almost_empty), 32'd1);
    chk("arst_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    chk("resume_head", bus.data_out, 32'h55);
    chk("resume_count", 32'(bus.count), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("resume_drain", 32'(bus.count), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("empty_pop_underflow", 32'(bus.underflow), 32'd1);

    repeat (2) @(negedge clk);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
